// File: rtl/uart_receiver_if.sv
// Serial-side bundle for uart_receiver: oversampling tick and line in,
// received word and frame status out.
interface uart_receiver_if #(
  parameter int dataBits = 8
);
  logic                sTick;
  logic                rx;
  logic [dataBits-1:0] dout;
  logic                rxDoneTick;
  logic                frameErr;
  logic                busy;

  // Line/tick source side (the testbench or the baud-generator wrapper).
  modport master (
    output sTick, rx,
    input  dout, rxDoneTick, frameErr, busy
  );

  // Receiver side.
  modport slave (
    input  sTick, rx,
    output dout, rxDoneTick, frameErr, busy
  );
endinterface

// File: rtl/uart_receiver.sv
// UART receiver with 16x oversampling. The start bit is confirmed at its
// midpoint, and every later bit is sampled 16 ticks after the previous one.
// The stop-bit length is set in ticks by sbTick.
module uart_receiver #(
  parameter int dataBits = 8,
  parameter int sbTick   = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_receiver_if.slave bus
);
  localparam int NW = (dataBits > 1) ? $clog2(dataBits) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  localparam logic [3:0]    MID_START = 4'd7;
  localparam logic [3:0]    BIT_LAST  = 4'd15;
  localparam logic [3:0]    SB_LAST   = 4'(sbTick - 1);
  localparam logic [NW-1:0] N_LAST    = NW'(dataBits - 1);

  logic [1:0]          state;
  logic [3:0]          s;
  logic [NW-1:0]       n;
  logic [dataBits-1:0] b;
  logic [1:0]          syncFf;
  logic                rxSync;

  assign rxSync = syncFf[1];

  // Two-flop synchronizer for the asynchronous line. It resets to idle-high,
  // so reset can never look like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) syncFf <= 2'b11;
    else        syncFf <= {syncFf[0], bus.rx};
  end

  // Frame FSM. rxDoneTick defaults low every cycle, so it is a one-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      s              <= '0;
      n              <= '0;
      b              <= '0;
      bus.dout       <= '0;
      bus.frameErr   <= 1'b0;
      bus.rxDoneTick <= 1'b0;
    end else begin
      bus.rxDoneTick <= 1'b0;
      case (state)
        IDLE: begin
          // A falling edge is acted on immediately, without waiting for a tick.
          if (!rxSync) begin
            state <= START;
            s     <= '0;
          end
        end
        START: begin
          if (bus.sTick) begin
            if (s == MID_START) begin
              s <= '0;
              if (!rxSync) begin
                state <= DATA;
                n     <= '0;
              end else begin
                // Line went high again before mid start bit: treat as a glitch.
                state <= IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (bus.sTick) begin
            if (s == BIT_LAST) begin
              s <= '0;
              b <= {rxSync, b[dataBits-1:1]};
              if (n == N_LAST) state <= STOP;
              else             n     <= n + NW'(1);
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: begin  // STOP
          if (bus.sTick) begin
            if (s == SB_LAST) begin
              state          <= IDLE;
              s              <= '0;
              bus.dout       <= b;
              bus.frameErr   <= ~rxSync;
              bus.rxDoneTick <= 1'b1;
            end else begin
              s <= s + 4'd1;
            end
          end
        end
      endcase
    end
  end

  // Busy means any frame activity, including an unconfirmed start bit.
  always_comb begin
    bus.busy = (state != IDLE);
  end
endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 8-bit frames, one sTick every 4 clk,
// 16 ticks per bit.
module tb_uart_receiver;
  logic clk;
  logic reset;
  int   checks   = 0;
  int   failures = 0;
  int   doneCnt  = 0;
  int   consec   = 0;
  logic prevDone = 1'b0;
  logic [7:0] lastDout = 8'h00;
  logic       lastErr  = 1'b0;

  uart_receiver_if #(.dataBits(8)) bus ();

  uart_receiver #(.dataBits(8), .sbTick(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every done pulse along with the word and status it delivered,
  // and counts any pulse that follows another on the next cycle.
  always @(negedge clk) begin
    if (bus.rxDoneTick) begin
      doneCnt  <= doneCnt + 1;
      lastDout <= bus.dout;
      lastErr  <= bus.frameErr;
      if (prevDone) consec <= consec + 1;
    end
    prevDone <= bus.rxDoneTick;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One tick = 4 clk with sTick high for exactly one of them.
  task automatic ticks(input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk) bus.sTick = 1'b1;
      @(negedge clk) bus.sTick = 1'b0;
      @(negedge clk);
      @(negedge clk);
    end
  endtask

  task automatic sendFrame(input logic [7:0] d, input logic stopV, input int stopT);
    bus.rx = 1'b0;
    ticks(16);
    for (int i = 0; i < 8; i++) begin
      bus.rx = d[i];
      ticks(16);
    end
    bus.rx = stopV;
    ticks(stopT);
    bus.rx = 1'b1;
  endtask

  initial begin
    reset     = 1'b0;
    bus.sTick = 1'b0;
    bus.rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dout",     32'(bus.dout), 32'h00);
    check("rst_frameErr", 32'(bus.frameErr), 32'h0);
    check("rst_done",     32'(bus.rxDoneTick), 32'h0);
    check("rst_busy",     32'(bus.busy), 32'h0);
    reset = 1'b1;
    ticks(4);

    // Clean frame 0xA5.
    sendFrame(8'hA5, 1'b1, 16);
    ticks(4);
    check("a5_count", 32'(doneCnt), 32'd1);
    check("a5_dout",  32'(lastDout), 32'hA5);
    check("a5_err",   32'(lastErr), 32'h0);
    check("a5_busy",  32'(bus.busy), 32'h0);
    check("a5_hold",  32'(bus.dout), 32'hA5);

    // Start glitch: line low for 3 ticks, then back high.
    bus.rx = 1'b0;
    ticks(3);
    bus.rx = 1'b1;
    ticks(1);
    check("gl_busy_mid", 32'(bus.busy), 32'h1);
    ticks(12);
    check("gl_busy_end", 32'(bus.busy), 32'h0);
    check("gl_count",    32'(doneCnt), 32'd1);
    check("gl_dout",     32'(bus.dout), 32'hA5);
    check("gl_err",      32'(bus.frameErr), 32'h0);

    // Low stop bit (held just past its sample point), then a clean 0x01.
    sendFrame(8'h3C, 1'b0, 10);
    ticks(20);
    check("fe_count", 32'(doneCnt), 32'd2);
    check("fe_dout",  32'(lastDout), 32'h3C);
    check("fe_err",   32'(lastErr), 32'h1);
    sendFrame(8'h01, 1'b1, 16);
    ticks(4);
    check("f01_count", 32'(doneCnt), 32'd3);
    check("f01_dout",  32'(bus.dout), 32'h01);
    check("f01_err",   32'(bus.frameErr), 32'h0);

    // Reset in the middle of data bit 4 of frame 0xFF.
    bus.rx = 1'b0;
    ticks(16);
    bus.rx = 1'b1;
    ticks(16 * 4 + 8);
    reset = 1'b0;
    @(negedge clk);
    check("mr_dout", 32'(bus.dout), 32'h00);
    check("mr_err",  32'(bus.frameErr), 32'h0);
    check("mr_done", 32'(bus.rxDoneTick), 32'h0);
    check("mr_busy", 32'(bus.busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    ticks(30);
    check("mr_count",     32'(doneCnt), 32'd3);
    check("mr_busy_post", 32'(bus.busy), 32'h0);
    sendFrame(8'h55, 1'b1, 16);
    ticks(4);
    check("f55_count", 32'(doneCnt), 32'd4);
    check("f55_dout",  32'(bus.dout), 32'h55);

    // Back-to-back frames: the second start edge follows the first stop bit directly.
    sendFrame(8'h12, 1'b1, 16);
    check("b2b_count1", 32'(doneCnt), 32'd5);
    check("b2b_dout1",  32'(lastDout), 32'h12);
    sendFrame(8'h34, 1'b1, 16);
    ticks(4);
    check("b2b_count2", 32'(doneCnt), 32'd6);
    check("b2b_dout2",  32'(lastDout), 32'h34);
    check("b2b_err2",   32'(lastErr), 32'h0);

    // Break: line held low for 12 bit times.
    bus.rx = 1'b0;
    ticks(153);
    check("brk_count", 32'(doneCnt), 32'd7);
    check("brk_dout",  32'(lastDout), 32'h00);
    check("brk_err",   32'(lastErr), 32'h1);
    check("brk_busy",  32'(bus.busy), 32'h1);
    ticks(192 - 153);
    bus.rx = 1'b1;
    ticks(4);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ticks(2);

    check("no_consec_done", 32'(consec), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 The block SHALL have parameter dataBits, default 8, giving the number of data bits per frame, LSB first.
REQ-002 The block SHALL have parameter sbTick, default 16, giving the number of sTick pulses in the stop-bit period (16 = 1 stop bit).
REQ-003 The block SHALL have port clk, input, 1 bit: single system clock, rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset asserted).
REQ-005 The block SHALL have port sTick, input, 1 bit: 16x-baud oversampling enable, one clk cycle wide per tick.
REQ-006 The block SHALL have port rx, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-007 The block SHALL have port dout, output, dataBits wide: last received data word.
REQ-008 The block SHALL have port rxDoneTick, output, 1 bit: one-clk pulse when a frame completes.
REQ-009 The block SHALL have port frameErr, output, 1 bit: stop bit of the last completed frame was sampled low.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever the state is not idle.

Function
REQ-011 rx SHALL pass through a two-flop synchronizer (rxSync) before any use; both flops SHALL reset to 1.
REQ-012 The FSM SHALL have four states, idle, start, data and stop, with a 4-bit tick counter s, a counter n of width ceil(log2(dataBits)), and a dataBits-wide shift register b.
REQ-013 idle: on any clk edge with rxSync==0, regardless of sTick, the FSM SHALL go to start with s=0.
REQ-014 start: on sTick with s==7 (mid start bit), the FSM SHALL go to data with s=0 and n=0 if rxSync==0; otherwise it SHALL return to idle as a glitch, with no rxDoneTick and no change to frameErr.
REQ-015 start: on sTick with s<7, the block SHALL set s=s+1.
REQ-016 data: on sTick with s==15, the block SHALL set s=0 and b={rxSync, b[dataBits-1:1]} (shift right, new bit into MSB); if n==dataBits-1 the FSM SHALL go to stop, else n=n+1.
REQ-017 data: on sTick with s<15, the block SHALL set s=s+1.
REQ-018 stop: on sTick with s==sbTick-1, the FSM SHALL go to idle; on the same clk edge dout<=b, frameErr<=~rxSync and rxDoneTick<=1.
REQ-019 stop: on sTick with s<sbTick-1, the block SHALL set s=s+1.
REQ-020 In every state, clk edges without sTick SHALL hold s, n, b and the state, except for the idle rule in REQ-013.
REQ-021 rxDoneTick SHALL be a registered output, high for exactly one clk cycle per completed frame, and never high on consecutive cycles.
REQ-022 dout and frameErr SHALL hold their values until the next completed frame; a glitch-aborted start SHALL change neither.
REQ-023 A frame with a low stop bit SHALL still update dout and pulse rxDoneTick, with frameErr=1.
REQ-024 Break (rx held low): after the frame completes with frameErr=1 and dout=0, the FSM SHALL re-enter start on the next clk edge.
REQ-025 busy SHALL be combinational: (state != idle).
REQ-026 Sampling latency: the start bit SHALL be confirmed 8 ticks after it is detected; each data bit SHALL be sampled 16 ticks after the previous sample; rxDoneTick SHALL rise 16*dataBits+sbTick+8 ticks after start detection, plus the synchronizer delay of 2 clk.

Reset
REQ-027 While reset==0, the block SHALL force state=idle, s=0, n=0, b=0, dout=0, frameErr=0, rxDoneTick=0 and synchronizer flops=1, asynchronously.
REQ-028 Reset asserted mid-frame SHALL abort the frame with no rxDoneTick; after release, reception SHALL restart only on a new falling edge of rx.

Verification
REQ-029 Frame 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) with a valid stop and sTick every 4 clk -> a single rxDoneTick, dout=0xA5, frameErr=0, busy low afterwards.
REQ-030 rx low for 3 ticks, then high -> FSM returns to idle at tick 8; rxDoneTick never asserts; dout and frameErr unchanged.
REQ-031 Frame 0x3C with the stop bit driven low -> rxDoneTick pulses, dout=0x3C, frameErr=1; a following valid frame 0x01 -> dout=0x01, frameErr=0.
REQ-032 reset pulsed low during data bit 4 of frame 0xFF -> all outputs 0, busy=0, no rxDoneTick; next frame 0x55 -> dout=0x55.
REQ-033 Two frames 0x12 and 0x34 back-to-back, with the second start edge immediately after the first stop -> two rxDoneTick pulses, dout=0x12 then 0x34.
REQ-034 rx held low for 12 bit times -> rxDoneTick with dout=0x00 and frameErr=1; busy stays high as a new start is detected.
